// File: rtl/dpram_banked_pkg.sv
// Shared definitions for the banked dual-port RAM: clear sequencer states,
// the legal read-latency range and a constant-evaluable log2 helper.
package dpram_banked_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int N_DELAY_MIN = 1;
  localparam int N_DELAY_MAX = 4;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/dpram_banked_bank.sv
// One RAM bank: byte-enabled write port and a single registered read port.
// The read returns the pre-write contents on a same-row collision.
module dpram_banked_bank #(
  parameter int DW = 32,
  parameter int RW = 14
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [DW/8-1:0] we,
  input  logic [RW-1:0]   waddr,
  input  logic [DW-1:0]   wdata,
  input  logic            re,
  input  logic [RW-1:0]   raddr,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem [0:(1 << RW) - 1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < DW / 8; i++) begin
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/dpram_banked.sv
// Banked dual-port RAM: byte-enabled write port, pipelined read port with
// write-first forwarding, and a sequencer that zeroes the whole array.
module dpram_banked
  import dpram_banked_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 16,
  parameter int NBANK   = 4,
  parameter int N_DELAY = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ena,
  input  logic [DW/8-1:0] wea,
  input  logic [AW-1:0]   addra,
  input  logic [DW-1:0]   dia,
  input  logic            enb,
  input  logic [AW-1:0]   addrb,
  output logic [DW-1:0]   dob,
  output logic            rvalid,
  input  logic            clr,
  output logic            busy
);

  localparam int NB   = DW / 8;
  localparam int BW   = clog2(NBANK);
  localparam int BI   = (BW > 0) ? BW : 1;
  localparam int RW   = (AW > BW) ? AW - BW : 1;
  localparam int ROWS = (1 << AW) / NBANK;
  localparam int ND   = (N_DELAY < N_DELAY_MIN) ? N_DELAY_MIN :
                        (N_DELAY > N_DELAY_MAX) ? N_DELAY_MAX : N_DELAY;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  clr_state_e    state;
  logic [RW-1:0] cnt;
  logic          clearing;
  logic          wr_ok;
  logic [BI-1:0] bank_a, bank_b, bank_q;
  logic [RW-1:0] row_a, row_b;
  logic [NB-1:0] fwd_mask, fwd_mask_q;
  logic [DW-1:0] fwd_data, fwd_data_q;
  logic [DW-1:0] bank_rdata [NBANK];
  logic [DW-1:0] rd_word;
  logic          v0;

  assign clearing = (state == ST_CLEAR);
  assign wr_ok    = ena && (state == ST_IDLE) && !clr;
  assign bank_a   = BI'(addra & AW'(NBANK - 1));
  assign bank_b   = BI'(addrb & AW'(NBANK - 1));
  assign row_a    = RW'(addra >> BW);
  assign row_b    = RW'(addrb >> BW);
  assign busy     = clearing;

  // Lanes the bank read will miss because they are being written this cycle.
  always_comb begin
    fwd_mask = '0;
    fwd_data = dia;
    if (clearing && (row_b == cnt)) begin
      fwd_mask = '1;
      fwd_data = '0;
    end else if (wr_ok && (addra == addrb)) begin
      fwd_mask = wea;
    end
  end

  for (genvar j = 0; j < NBANK; j++) begin : g_bank
    logic [NB-1:0] we;
    logic [RW-1:0] waddr;
    logic [DW-1:0] wdata;

    always_comb begin
      we    = '0;
      waddr = row_a;
      wdata = dia;
      if (clearing) begin
        we    = '1;
        waddr = cnt;
        wdata = '0;
      end else if (wr_ok && (bank_a == BI'(j))) begin
        we = wea;
      end
    end

    dpram_banked_bank #(.DW(DW), .RW(RW)) u_bank (
      .clk   (clk),
      .rstn  (rstn),
      .we    (we),
      .waddr (waddr),
      .wdata (wdata),
      .re    (enb),
      .raddr (row_b),
      .rdata (bank_rdata[j])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v0         <= 1'b0;
      bank_q     <= '0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else begin
      v0 <= enb;
      if (enb) begin
        bank_q     <= bank_b;
        fwd_mask_q <= fwd_mask;
        fwd_data_q <= fwd_data;
      end
    end
  end

  always_comb begin
    rd_word = bank_rdata[bank_q];
    for (int i = 0; i < NB; i++) begin
      if (fwd_mask_q[i]) rd_word[8*i +: 8] = fwd_data_q[8*i +: 8];
    end
  end

  // Stage-0 registers only load on a read, so rd_word already holds between reads.
  if (ND == 1) begin : g_direct
    assign dob    = rd_word;
    assign rvalid = v0;
  end else begin : g_pipe
    logic [DW-1:0] pd [ND-1];
    logic [ND-2:0] pv;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        pv <= '0;
        for (int k = 0; k < ND - 1; k++) pd[k] <= '0;
      end else begin
        pv[0] <= v0;
        if (v0) pd[0] <= rd_word;
        for (int k = 1; k < ND - 1; k++) begin
          pv[k] <= pv[k-1];
          if (pv[k-1]) pd[k] <= pd[k-1];
        end
      end
    end

    assign dob    = pd[ND-2];
    assign rvalid = pv[ND-2];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr) begin
            state <= ST_CLEAR;
            cnt   <= '0;
          end
        end
        ST_CLEAR: begin
          if (cnt == LAST_ROW) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpram_banked.sv
// Bench for dpram_banked: two instances (read latency 1 and 3) share one
// stimulus stream and are scored against an address-level memory model.
module tb_dpram_banked;

  localparam int DEPTH = 64;
  localparam int NBANK = 4;
  localparam int ROWS  = DEPTH / NBANK;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] pre;
    logic [3:0]  wea;
    logic [31:0] data;
    logic [31:0] exp_word;
  } vec_t;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic        ena  = 1'b0;
  logic        enb  = 1'b0;
  logic        clr  = 1'b0;
  logic [3:0]  wea  = '0;
  logic [5:0]  addra = '0;
  logic [5:0]  addrb = '0;
  logic [31:0] dia  = '0;
  logic [31:0] dob1, dob3;
  logic        rvalid1, rvalid3, busy1, busy3;

  int n_checks = 0;
  int n_fail   = 0;
  bit sb_on    = 1'b0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] fill_val [DEPTH];
  bit          m_busy = 1'b0;
  int          m_row  = 0;
  bit          hist_v [3];
  logic [31:0] hist_d [3];
  bit          exp_rv1 = 1'b0;
  bit          exp_rv3 = 1'b0;
  logic [31:0] exp_dob1 = '0;
  logic [31:0] exp_dob3 = '0;
  logic [31:0] m_rd;
  vec_t        vecs [6];

  always #5 clk = ~clk;

  dpram_banked #(.DW(32), .AW(6), .NBANK(NBANK), .N_DELAY(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .ena(ena), .wea(wea), .addra(addra), .dia(dia),
    .enb(enb), .addrb(addrb), .dob(dob1), .rvalid(rvalid1), .clr(clr), .busy(busy1)
  );

  dpram_banked #(.DW(32), .AW(6), .NBANK(NBANK), .N_DELAY(3)) u_dut3 (
    .clk(clk), .rstn(rstn), .ena(ena), .wea(wea), .addra(addra), .dia(dia),
    .enb(enb), .addrb(addrb), .dob(dob3), .rvalid(rvalid3), .clr(clr), .busy(busy3)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic a_en, input logic [3:0] a_we, input logic [5:0] a_addr,
                               input logic [31:0] a_data, input logic b_en, input logic [5:0] b_addr,
                               input logic c_clr);
    ena = a_en; wea = a_we; addra = a_addr; dia = a_data;
    enb = b_en; addrb = b_addr; clr = c_clr;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'h0, 6'd0, 32'h0, 1'b0, 6'd0, 1'b0);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic fillAll();
    for (int a = 0; a < DEPTH; a++) begin
      fill_val[a] = $urandom | 32'h1;
      applyStimulus(1'b1, 4'hF, 6'(a), fill_val[a], 1'b0, 6'd0, 1'b0);
      tick();
    end
    idle();
  endtask

  // Memory model: each edge applies the clear row or the accepted write, then
  // services the read, so a read sees whatever the array holds after that edge.
  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_busy = 1'b0;
        m_row  = 0;
        for (int k = 0; k < 3; k++) begin
          hist_v[k] = 1'b0;
          hist_d[k] = '0;
        end
        exp_rv1 = 1'b0; exp_rv3 = 1'b0;
        exp_dob1 = '0;  exp_dob3 = '0;
      end else begin
        if (m_busy) begin
          for (int b = 0; b < NBANK; b++) ref_mem[m_row * NBANK + b] = '0;
        end else if (ena && !clr) begin
          for (int i = 0; i < 4; i++) begin
            if (wea[i]) ref_mem[addra][8*i +: 8] = dia[8*i +: 8];
          end
        end
        m_rd = enb ? ref_mem[addrb] : 32'h0;
        if (m_busy) begin
          if (m_row == ROWS - 1) m_busy = 1'b0;
          else m_row++;
        end else if (clr) begin
          m_busy = 1'b1;
          m_row  = 0;
        end
        hist_v[2] = hist_v[1]; hist_d[2] = hist_d[1];
        hist_v[1] = hist_v[0]; hist_d[1] = hist_d[0];
        hist_v[0] = enb;       hist_d[0] = m_rd;
        exp_rv1 = hist_v[0];
        if (hist_v[0]) exp_dob1 = hist_d[0];
        exp_rv3 = hist_v[2];
        if (hist_v[2]) exp_dob3 = hist_d[2];
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (sb_on) begin
        checkOutput("sb_rvalid1", 32'(rvalid1), 32'(exp_rv1));
        checkOutput("sb_dob1", dob1, exp_dob1);
        checkOutput("sb_rvalid3", 32'(rvalid3), 32'(exp_rv3));
        checkOutput("sb_dob3", dob3, exp_dob3);
        checkOutput("sb_busy1", 32'(busy1), 32'(m_busy));
        checkOutput("sb_busy3", 32'(busy3), 32'(m_busy));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int          busy_cycles;
    int          rv3_count;
    logic [31:0] exp_w;
    logic [5:0]  ra;
    logic [5:0]  rb;

    vecs[0] = '{addr: 6'd5,  pre: 32'h00000000, wea: 4'hF, data: 32'hDEADBEEF, exp_word: 32'hDEADBEEF};
    vecs[1] = '{addr: 6'd9,  pre: 32'h11223344, wea: 4'h5, data: 32'hAABBCCDD, exp_word: 32'h11BB33DD};
    vecs[2] = '{addr: 6'd12, pre: 32'h01234567, wea: 4'h0, data: 32'hFFFFFFFF, exp_word: 32'h01234567};
    vecs[3] = '{addr: 6'd63, pre: 32'h00000000, wea: 4'hA, data: 32'h12345678, exp_word: 32'h12005600};
    vecs[4] = '{addr: 6'd0,  pre: 32'hCAFEF00D, wea: 4'h3, data: 32'h0000BEEF, exp_word: 32'hCAFEBEEF};
    vecs[5] = '{addr: 6'd46, pre: 32'hFFFFFFFF, wea: 4'h8, data: 32'h00ABCDEF, exp_word: 32'h00FFFFFF};

    idle();
    repeat (3) tick();
    checkOutput("reset_busy", 32'(busy1), 32'h0);
    checkOutput("reset_rvalid1", 32'(rvalid1), 32'h0);
    checkOutput("reset_dob1", dob1, 32'h0);
    checkOutput("reset_rvalid3", 32'(rvalid3), 32'h0);
    checkOutput("reset_dob3", dob3, 32'h0);
    rstn  = 1'b1;
    sb_on = 1'b1;
    tick();

    fillAll();
    tick();

    for (int v = 0; v < 6; v++) begin
      applyStimulus(1'b1, 4'hF, vecs[v].addr, vecs[v].pre, 1'b0, 6'd0, 1'b0);
      tick();
      applyStimulus(1'b1, vecs[v].wea, vecs[v].addr, vecs[v].data, 1'b0, 6'd0, 1'b0);
      tick();
      applyStimulus(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, vecs[v].addr, 1'b0);
      tick();
      idle();
      checkOutput($sformatf("vec%0d_rvalid1", v), 32'(rvalid1), 32'h1);
      checkOutput($sformatf("vec%0d_dob1", v), dob1, vecs[v].exp_word);
      tick();
      tick();
      checkOutput($sformatf("vec%0d_rvalid3", v), 32'(rvalid3), 32'h1);
      checkOutput($sformatf("vec%0d_dob3", v), dob3, vecs[v].exp_word);
      tick();
    end

    applyStimulus(1'b1, 4'hF, 6'd3, 32'h0, 1'b0, 6'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'hC, 6'd3, 32'hFFFF0000, 1'b1, 6'd3, 1'b0);
    tick();
    idle();
    checkOutput("coll_dob1", dob1, 32'hFFFF0000);
    checkOutput("coll_rvalid3_t1", 32'(rvalid3), 32'h0);
    tick();
    checkOutput("coll_rvalid3_t2", 32'(rvalid3), 32'h0);
    tick();
    checkOutput("coll_rvalid3_t3", 32'(rvalid3), 32'h1);
    checkOutput("coll_dob3", dob3, 32'hFFFF0000);
    tick();
    checkOutput("coll_rvalid3_pulse", 32'(rvalid3), 32'h0);

    for (int a = 0; a < 16; a++) begin
      applyStimulus(1'b1, 4'hF, 6'(a), 32'(a), 1'b0, 6'd0, 1'b0);
      tick();
    end
    rv3_count = 0;
    for (int a = 0; a < 16; a++) begin
      applyStimulus(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'(a), 1'b0);
      tick();
      if (rvalid3) rv3_count++;
      checkOutput($sformatf("stream_rvalid1_%0d", a), 32'(rvalid1), 32'h1);
      checkOutput($sformatf("stream_dob1_%0d", a), dob1, 32'(a));
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      tick();
      if (rvalid3) rv3_count++;
    end
    checkOutput("stream_rvalid1_end", 32'(rvalid1), 32'h0);
    checkOutput("stream_dob1_hold", dob1, 32'd15);
    checkOutput("stream_rvalid3_count", 32'(rv3_count), 32'd16);
    checkOutput("stream_dob3_hold", dob3, 32'd15);

    fillAll();
    tick();
    applyStimulus(1'b1, 4'hF, 6'd7, 32'h77777777, 1'b0, 6'd0, 1'b1);
    tick();
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy1) break;
      busy_cycles++;
      if (busy_cycles == 5) applyStimulus(1'b1, 4'hF, 6'd20, 32'h12345678, 1'b0, 6'd0, 1'b0);
      else if (busy_cycles == 8) applyStimulus(1'b0, 4'h0, 6'd0, 32'h0, 1'b0, 6'd0, 1'b1);
      else applyStimulus(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'($urandom_range(0, 63)), 1'b0);
      tick();
    end
    checkOutput("clear_busy_cycles", 32'(busy_cycles), 32'd16);
    applyStimulus(1'b1, 4'hF, 6'd21, 32'h21212121, 1'b0, 6'd0, 1'b0);
    tick();
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'(a), 1'b0);
      tick();
      exp_w = (a == 21) ? 32'h21212121 : 32'h0;
      checkOutput($sformatf("clear_dob1_%0d", a), dob1, exp_w);
    end
    idle();
    tick();

    fillAll();
    tick();
    applyStimulus(1'b0, 4'h0, 6'd0, 32'h0, 1'b0, 6'd0, 1'b1);
    tick();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'($urandom_range(0, 63)), 1'b0);
      tick();
    end
    #2 rstn = 1'b0;
    #1;
    checkOutput("rstclr_busy1", 32'(busy1), 32'h0);
    checkOutput("rstclr_busy3", 32'(busy3), 32'h0);
    checkOutput("rstclr_rvalid1", 32'(rvalid1), 32'h0);
    checkOutput("rstclr_dob1", dob1, 32'h0);
    checkOutput("rstclr_rvalid3", 32'(rvalid3), 32'h0);
    checkOutput("rstclr_dob3", dob3, 32'h0);
    idle();
    tick();
    #2 rstn = 1'b1;
    tick();
    for (int a = 0; a < DEPTH; a++) begin
      applyStimulus(1'b0, 4'h0, 6'd0, 32'h0, 1'b1, 6'(a), 1'b0);
      tick();
      exp_w = (a < 32) ? 32'h0 : fill_val[a];
      checkOutput($sformatf("rstclr_dob1_%0d", a), dob1, exp_w);
    end
    idle();
    tick();

    for (int c = 0; c < 400; c++) begin
      ra = 6'($urandom_range(0, 63));
      rb = ($urandom_range(0, 3) == 0) ? ra : 6'($urandom_range(0, 63));
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom), ra, $urandom,
                    ($urandom_range(0, 9) < 6), rb, ($urandom_range(0, 63) == 0));
      tick();
    end
    idle();
    repeat (20) tick();
    sb_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
